// File: rtl/screensaver_video_gen.sv
`default_nettype none
// ============================================================================
// Module  : screensaver_video_gen
// Brief   : VGA timing generator with a bouncing-box screensaver and a
//           registered RGB/sync output stage. Optional macro BOUNCE_COLOR_EN
//           enables a colour index that advances on every bounce.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module screensaver_video_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int COLOR_W   = 4,
  parameter int BOX_W     = 64,
  parameter int BOX_H     = 48,
  parameter int SPEED     = 2,
  parameter int X0        = 0,
  parameter int Y0        = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               visible,
  output logic [31:0]        frame
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Compare constants carry one spare bit so range ends never overflow.
  localparam logic [HW:0] C_H_LAST   = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] C_H_VIS    = (HW+1)'(H_VISIBLE);
  localparam logic [HW:0] C_HS_START = (HW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [HW:0] C_HS_END   = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW:0] C_BOX_W    = (HW+1)'(BOX_W);
  localparam logic [HW:0] C_X_MAX    = (HW+1)'(H_VISIBLE - BOX_W);
  localparam logic [HW:0] C_SPEED_X  = (HW+1)'(SPEED);
  localparam logic [VW:0] C_V_LAST   = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] C_V_VIS    = (VW+1)'(V_VISIBLE);
  localparam logic [VW:0] C_V_VLAST  = (VW+1)'(V_VISIBLE - 1);
  localparam logic [VW:0] C_VS_START = (VW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [VW:0] C_VS_END   = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW:0] C_BOX_H    = (VW+1)'(BOX_H);
  localparam logic [VW:0] C_Y_MAX    = (VW+1)'(V_VISIBLE - BOX_H);
  localparam logic [VW:0] C_SPEED_Y  = (VW+1)'(SPEED);
  localparam logic        C_SYNC_ACT = (SYNC_POL != 0);

  logic [HW-1:0]      r_hc, r_bx, w_bx_next;
  logic [VW-1:0]      r_vc, r_by, w_by_next;
  logic               r_x_left, r_y_up, w_x_left_next, w_y_up_next;
  logic               w_bounce_x, w_bounce_y;
  logic [HW:0]        w_hc_x, w_bx_x;
  logic [VW:0]        w_vc_x, w_by_x;
  logic               w_h_wrap, w_v_wrap, w_vis, w_in_box, w_frame_evt;
  logic               w_hs_act, w_vs_act;
  logic [COLOR_W-1:0] w_r, w_g, w_b;

  assign w_hc_x      = {1'b0, r_hc};
  assign w_vc_x      = {1'b0, r_vc};
  assign w_bx_x      = {1'b0, r_bx};
  assign w_by_x      = {1'b0, r_by};
  assign w_h_wrap    = (w_hc_x == C_H_LAST);
  assign w_v_wrap    = (w_vc_x == C_V_LAST);
  assign w_vis       = (w_hc_x < C_H_VIS) && (w_vc_x < C_V_VIS);
  assign w_hs_act    = (w_hc_x >= C_HS_START) && (w_hc_x < C_HS_END);
  assign w_vs_act    = (w_vc_x >= C_VS_START) && (w_vc_x < C_VS_END);
  assign w_in_box    = (w_hc_x >= w_bx_x) && (w_hc_x < w_bx_x + C_BOX_W) &&
                       (w_vc_x >= w_by_x) && (w_vc_x < w_by_x + C_BOX_H);
  assign w_frame_evt = w_h_wrap && (w_vc_x == C_V_VLAST);

  // Box motion with clamping at the visible edges; a clamp reverses direction.
  always_comb begin
    w_bx_next     = r_bx;
    w_x_left_next = r_x_left;
    w_bounce_x    = 1'b0;
    if (!r_x_left) begin
      if (w_bx_x + C_SPEED_X >= C_X_MAX) begin
        w_bx_next     = C_X_MAX[HW-1:0];
        w_x_left_next = 1'b1;
        w_bounce_x    = 1'b1;
      end else begin
        w_bx_next = r_bx + C_SPEED_X[HW-1:0];
      end
    end else if (w_bx_x <= C_SPEED_X) begin
      w_bx_next     = '0;
      w_x_left_next = 1'b0;
      w_bounce_x    = 1'b1;
    end else begin
      w_bx_next = r_bx - C_SPEED_X[HW-1:0];
    end
  end

  always_comb begin
    w_by_next   = r_by;
    w_y_up_next = r_y_up;
    w_bounce_y  = 1'b0;
    if (!r_y_up) begin
      if (w_by_x + C_SPEED_Y >= C_Y_MAX) begin
        w_by_next   = C_Y_MAX[VW-1:0];
        w_y_up_next = 1'b1;
        w_bounce_y  = 1'b1;
      end else begin
        w_by_next = r_by + C_SPEED_Y[VW-1:0];
      end
    end else if (w_by_x <= C_SPEED_Y) begin
      w_by_next   = '0;
      w_y_up_next = 1'b0;
      w_bounce_y  = 1'b1;
    end else begin
      w_by_next = r_by - C_SPEED_Y[VW-1:0];
    end
  end

`ifdef BOUNCE_COLOR_EN
  logic [2:0] r_color;

  // Index cycles 1..7, never 0, so the box is never black.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_color <= 3'd7;
    end else if (w_frame_evt && (w_bounce_x || w_bounce_y)) begin
      r_color <= (r_color == 3'd7) ? 3'd1 : r_color + 3'd1;
    end
  end

  assign w_r = {COLOR_W{r_color[2]}};
  assign w_g = {COLOR_W{r_color[1]}};
  assign w_b = {COLOR_W{r_color[0]}};
`else
  assign w_r = {COLOR_W{1'b1}};
  assign w_g = {COLOR_W{1'b1}};
  assign w_b = {COLOR_W{1'b1}};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hc     <= '0;
      r_vc     <= '0;
      r_bx     <= HW'(X0);
      r_by     <= VW'(Y0);
      r_x_left <= 1'b0;
      r_y_up   <= 1'b0;
      frame    <= '0;
    end else begin
      r_hc <= w_h_wrap ? '0 : r_hc + HW'(1);
      if (w_h_wrap) begin
        r_vc <= w_v_wrap ? '0 : r_vc + VW'(1);
      end
      if (w_frame_evt) begin
        frame    <= frame + 32'd1;
        r_bx     <= w_bx_next;
        r_by     <= w_by_next;
        r_x_left <= w_x_left_next;
        r_y_up   <= w_y_up_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync   <= ~C_SYNC_ACT;
      vsync   <= ~C_SYNC_ACT;
      visible <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      hsync   <= w_hs_act ? C_SYNC_ACT : ~C_SYNC_ACT;
      vsync   <= w_vs_act ? C_SYNC_ACT : ~C_SYNC_ACT;
      visible <= w_vis;
      r       <= (w_vis && w_in_box) ? w_r : '0;
      g       <= (w_vis && w_in_box) ? w_g : '0;
      b       <= (w_vis && w_in_box) ? w_b : '0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_screensaver_video_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_screensaver_video_gen
// Brief   : Self-checking bench for screensaver_video_gen on a small raster,
//           with random-length runs and random mid-line asynchronous resets.
// Revision: 1.0 - initial release
// ============================================================================
module tb_screensaver_video_gen;
  localparam int HV = 16, HF = 2, HS = 2, HB = 2;
  localparam int VV = 8,  VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int CW = 4, BW = 4, BH = 2, SP = 3, SPOL = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsync, vsync, visible;
  logic [CW-1:0] r, g, b;
  logic [31:0]   frame;

  int checks = 0;
  int errors = 0;

  // Reference model state: elapsed raster cycles, box geometry, frame count.
  int          t, mbx, mby, mdx, mdy, mcol;
  int unsigned mframe;

  screensaver_video_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(SPOL), .COLOR_W(CW), .BOX_W(BW), .BOX_H(BH),
    .SPEED(SP), .X0(0), .Y0(0)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .visible(visible), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; mbx = 0; mby = 0; mdx = 1; mdy = 1; mcol = 7; mframe = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'(SPOL == 0));
    chk({tag, "_vsync"}, 32'(vsync), 32'(SPOL == 0));
    chk({tag, "_visible"}, 32'(visible), 32'd0);
    chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
    chk({tag, "_frame"}, frame, 32'd0);
  endtask

  // One pixel clock: predict outputs for the current raster position, apply
  // the per-frame box move, then compare away from the active edge.
  task automatic step();
    int hc, vc, ev, ex, ey, inb, bnc;
    logic [CW-1:0] er, eg, eb;
    @(posedge clk);
    hc  = t % HT;
    vc  = (t / HT) % VT;
    ev  = (hc < HV && vc < VV) ? 1 : 0;
    ex  = (hc >= HV + HF && hc < HV + HF + HS) ? 1 : 0;
    ey  = (vc >= VV + VF && vc < VV + VF + VS) ? 1 : 0;
    inb = (ev == 1 && hc >= mbx && hc < mbx + BW && vc >= mby && vc < mby + BH) ? 1 : 0;
`ifdef BOUNCE_COLOR_EN
    er = ((mcol >> 2) & 1) != 0 ? '1 : '0;
    eg = ((mcol >> 1) & 1) != 0 ? '1 : '0;
    eb = (mcol & 1) != 0 ? '1 : '0;
`else
    er = '1; eg = '1; eb = '1;
`endif
    if (inb == 0) begin
      er = '0; eg = '0; eb = '0;
    end
    if (hc == HT - 1 && vc == VV - 1) begin
      mframe++;
      bnc = 0;
      if (mdx > 0) begin
        if (mbx + SP >= HV - BW) begin mbx = HV - BW; mdx = -1; bnc = 1; end
        else mbx += SP;
      end else if (mbx <= SP) begin mbx = 0; mdx = 1; bnc = 1; end
      else mbx -= SP;
      if (mdy > 0) begin
        if (mby + SP >= VV - BH) begin mby = VV - BH; mdy = -1; bnc = 1; end
        else mby += SP;
      end else if (mby <= SP) begin mby = 0; mdy = 1; bnc = 1; end
      else mby -= SP;
      if (bnc != 0) mcol = (mcol == 7) ? 1 : mcol + 1;
    end
    t++;
    @(negedge clk);
    chk("hsync", 32'(hsync), 32'((ex != 0) ? (SPOL != 0) : (SPOL == 0)));
    chk("vsync", 32'(vsync), 32'((ey != 0) ? (SPOL != 0) : (SPOL == 0)));
    chk("visible", 32'(visible), 32'(ev));
    chk("r", 32'(r), 32'(er));
    chk("g", 32'(g), 32'(eg));
    chk("b", 32'(b), 32'(eb));
    chk("frame", frame, mframe);
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;

    // Several random-length runs, each cut short by a mid-cycle async reset.
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(200, 2600)) step();
      #($urandom_range(1, 4));
      rst = 1'b0;
      #1;
      check_reset_values("async_rst");
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("held_rst");
      @(negedge clk);
      rst = 1'b1;
      model_reset();
    end

    // Long run covering both edge bounces and the corner hit on each axis.
    repeat (12 * HT * VT) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
